// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: multi-channel servo position scheduler.
// Holds a target position per channel (written through a valid/ready
// handshake) and, once per update period, sweeps every channel and slews
// its current position toward the target by at most STEP counts.
// The current positions feed the `val` inputs of per-channel servo PWMs.
module servo_ramp_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int CH_BITS   = 2,
  parameter int VAL_BITS  = 8,
  parameter int TICK_BITS = 20,
  parameter int STEP      = 4,
  parameter int CENTER    = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [CH_BITS-1:0]         wr_ch,
  input  logic [VAL_BITS-1:0]        wr_val,
  output logic                       wr_ready,
  output logic [NUM_CH*VAL_BITS-1:0] val,
  output logic [NUM_CH-1:0]          busy,
  output logic                       tick
);

  typedef enum logic {
    IDLE,
    UPDATE
  } state_t;

  localparam logic [CH_BITS-1:0]  LAST_CH  = CH_BITS'(NUM_CH - 1);
  localparam logic [VAL_BITS:0]   STEP_W   = (VAL_BITS + 1)'(STEP);
  localparam logic [VAL_BITS-1:0] CENTER_V = VAL_BITS'(CENTER);

  state_t               state, state_nxt;
  logic [CH_BITS-1:0]   ch_idx, ch_idx_nxt;
  logic [TICK_BITS-1:0] tick_cnt;
  logic [VAL_BITS-1:0]  target  [NUM_CH];
  logic [VAL_BITS-1:0]  current [NUM_CH];
  logic                 wr_fire;

  // One slew step of c toward t, clamped so the target is hit exactly.
  // Done one bit wider than the position so c+STEP and t+STEP cannot wrap.
  function automatic logic [VAL_BITS-1:0] slew_step(input logic [VAL_BITS-1:0] c,
                                                     input logic [VAL_BITS-1:0] t);
    logic [VAL_BITS:0] c_w;
    logic [VAL_BITS:0] t_w;
    logic [VAL_BITS:0] moved;
    c_w       = {1'b0, c};
    t_w       = {1'b0, t};
    moved     = c_w;
    slew_step = c;
    if (c_w < t_w) begin
      moved     = c_w + STEP_W;
      slew_step = (moved >= t_w) ? t : moved[VAL_BITS-1:0];
    end else if (c_w > t_w) begin
      moved     = c_w - STEP_W;
      slew_step = (c_w >= t_w + STEP_W) ? moved[VAL_BITS-1:0] : t;
    end
  endfunction

  // Free-running update-period counter; tick marks its last count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) tick_cnt <= '0;
    else     tick_cnt <= tick_cnt + TICK_BITS'(1);
  end

  assign tick    = &tick_cnt;
  assign wr_fire = wr_en & wr_ready;

  // FSM state and sweep channel index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ch_idx <= '0;
    end else begin
      state  <= state_nxt;
      ch_idx <= ch_idx_nxt;
    end
  end

  // Next-state logic: IDLE accepts writes; UPDATE visits one channel per cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    state_nxt  = state;
    ch_idx_nxt = ch_idx;
    wr_ready   = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (tick) begin
          state_nxt  = UPDATE;
          ch_idx_nxt = '0;
        end
      end
      UPDATE: begin
        if (ch_idx == LAST_CH) begin
          state_nxt  = IDLE;
          ch_idx_nxt = '0;
        end else begin
          ch_idx_nxt = ch_idx + CH_BITS'(1);
        end
      end
      default: begin
        state_nxt  = IDLE;
        ch_idx_nxt = '0;
      end
    endcase
  end

  // Target writes and per-channel slewing. Writes to an index past the last
  // channel match no k and so are accepted without effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these per-channel arrays are plain flops, so they are reset like any other state.
      for (int k = 0; k < NUM_CH; k++) begin
        target[k]  <= CENTER_V;
        current[k] <= CENTER_V;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_fire && (wr_ch == CH_BITS'(k))) target[k] <= wr_val;
        if ((state == UPDATE) && (ch_idx == CH_BITS'(k)))
          current[k] <= slew_step(current[k], target[k]);
      end
    end
  end

  // Pack current positions onto val and flag channels still in motion.
  always_comb begin
    val  = '0;
    busy = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      val[k*VAL_BITS +: VAL_BITS] = current[k];
      busy[k]                     = (current[k] != target[k]);
    end
  end

endmodule
